// File: rtl/projection_pipe.sv
// Perspective projection of one signed vertex to screen space:
//   ox = x*FOCAL_D/z, oy = y*FOCAL_D/z (truncated toward zero, saturated to WIDTH bits).
// Two restoring dividers share the denominator |z| and retire one quotient bit per cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a vertex; latches x/y/z on in_valid
// MUL   | forms |x|*FOCAL_D, |y|*FOCAL_D, |z| and signs; near-plane clip check
// DIV   | NW restoring-divide iterations, MSB first
// FIX   | applies signs, saturates, registers ox/oy
// OUT   | result held on out_valid until out_ready
module projection_pipe #(
    parameter int WIDTH     = 32,
    parameter int FOCAL_W   = 16,
    parameter int FOCAL_D   = 600,
    parameter int NEAR_Z    = 1,
    parameter int NUM_VERTS = 3,
    localparam int IDX_W    = (NUM_VERTS > 1) ? $clog2(NUM_VERTS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ox,
    output logic [WIDTH-1:0] oy,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_clip,
    output logic             out_sat
);

    localparam int NW = WIDTH + FOCAL_W;
    localparam int CW = $clog2(NW);
    localparam logic [NW-1:0] FOCAL = NW'(FOCAL_D);
    // Largest magnitude representable as a positive WIDTH-bit signed value.
    localparam logic [NW-1:0] MAX_POS = {{(NW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] NEAR_ZS = WIDTH'(NEAR_Z);
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] x_r, y_r, z_r;
    logic [WIDTH-1:0] mag_x, mag_y, mag_z;
    logic             z_clip;

    // num_* holds the dividend and fills with quotient bits from the LSB as it shifts.
    logic [NW-1:0]    num_x, num_y;
    logic [WIDTH-1:0] rem_x, rem_y;
    logic [WIDTH-1:0] den;
    logic             neg_x, neg_y;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sh_x, sh_y;
    logic             ge_x, ge_y;
    logic [WIDTH-1:0] rem_x_nxt, rem_y_nxt;

    logic             sat_x, sat_y;
    logic [WIDTH-1:0] fix_x, fix_y;

    // Magnitudes of the latched vertex and the near-plane test.
    always_comb begin
        mag_x  = x_r[WIDTH-1] ? (~x_r) + WIDTH'(1) : x_r;
        mag_y  = y_r[WIDTH-1] ? (~y_r) + WIDTH'(1) : y_r;
        mag_z  = z_r[WIDTH-1] ? (~z_r) + WIDTH'(1) : z_r;
        z_clip = $signed(z_r) < NEAR_ZS;
    end

    // One restoring-divide step for each coordinate against the shared divisor.
    always_comb begin
        sh_x      = {rem_x, num_x[NW-1]};
        sh_y      = {rem_y, num_y[NW-1]};
        ge_x      = sh_x >= {1'b0, den};
        ge_y      = sh_y >= {1'b0, den};
        // The partial remainder always stays below den, so the low WIDTH bits suffice.
        rem_x_nxt = ge_x ? sh_x[WIDTH-1:0] - den : sh_x[WIDTH-1:0];
        rem_y_nxt = ge_y ? sh_y[WIDTH-1:0] - den : sh_y[WIDTH-1:0];
    end

    // Sign application and saturation of the finished quotients.
    always_comb begin
        sat_x = num_x > MAX_POS;
        sat_y = num_y > MAX_POS;
        if (sat_x) begin
            fix_x = neg_x ? SAT_NEG : SAT_POS;
        end else begin
            fix_x = neg_x ? (~num_x[WIDTH-1:0]) + WIDTH'(1) : num_x[WIDTH-1:0];
        end
        if (sat_y) begin
            fix_y = neg_y ? SAT_NEG : SAT_POS;
        end else begin
            fix_y = neg_y ? (~num_y[WIDTH-1:0]) + WIDTH'(1) : num_y[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_MUL;
            end
            S_MUL: state_nxt = z_clip ? S_OUT : S_DIV;
            S_DIV: if (cnt == '0) state_nxt = S_FIX;
            S_FIX: state_nxt = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: vertex capture, product formation, divide iterations and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r      <= '0;
            y_r      <= '0;
            z_r      <= '0;
            num_x    <= '0;
            num_y    <= '0;
            rem_x    <= '0;
            rem_y    <= '0;
            den      <= '0;
            neg_x    <= 1'b0;
            neg_y    <= 1'b0;
            cnt      <= '0;
            ox       <= '0;
            oy       <= '0;
            out_clip <= 1'b0;
            out_sat  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_r <= x;
                        y_r <= y;
                        z_r <= z;
                    end
                end
                S_MUL: begin
                    num_x <= NW'(mag_x) * FOCAL;
                    num_y <= NW'(mag_y) * FOCAL;
                    rem_x <= '0;
                    rem_y <= '0;
                    den   <= mag_z;
                    neg_x <= x_r[WIDTH-1] ^ z_r[WIDTH-1];
                    neg_y <= y_r[WIDTH-1] ^ z_r[WIDTH-1];
                    cnt   <= CW'(NW - 1);
                    if (z_clip) begin
                        ox       <= '0;
                        oy       <= '0;
                        out_clip <= 1'b1;
                        out_sat  <= 1'b0;
                    end else begin
                        out_clip <= 1'b0;
                    end
                end
                S_DIV: begin
                    num_x <= {num_x[NW-2:0], ge_x};
                    num_y <= {num_y[NW-2:0], ge_y};
                    rem_x <= rem_x_nxt;
                    rem_y <= rem_y_nxt;
                    cnt   <= cnt - CW'(1);
                end
                S_FIX: begin
                    ox      <= fix_x;
                    oy      <= fix_y;
                    out_sat <= sat_x | sat_y;
                end
                default: ;
            endcase
        end
    end

    // Vertex index within the primitive; advances on each output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx <= '0;
        end else if (state == S_OUT && out_ready) begin
            if (out_idx == IDX_W'(NUM_VERTS - 1)) out_idx <= '0;
            else out_idx <= out_idx + IDX_W'(1);
        end
    end

    assign out_last = (out_idx == IDX_W'(NUM_VERTS - 1));

endmodule

// File: tb/tb_projection_pipe.sv
// Self-checking bench for projection_pipe: directed corner vertices plus randomized
// vertices compared against an arithmetic reference of the projection.
module tb_projection_pipe;

    localparam int  WIDTH     = 32;
    localparam int  FOCAL_D   = 600;
    localparam int  NEAR_Z    = 1;
    localparam int  NUM_VERTS = 3;
    localparam int  NW        = 48;
    localparam longint MAXP   = 64'sd2147483647;
    localparam longint MINN   = -64'sd2147483648;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x, y, z;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ox, oy;
    logic [1:0]       out_idx;
    logic             out_last;
    logic             out_clip;
    logic             out_sat;

    int n_cmp;
    int n_bad;
    int idx_ref;

    projection_pipe #(
        .WIDTH(WIDTH), .FOCAL_W(16), .FOCAL_D(FOCAL_D), .NEAR_Z(NEAR_Z), .NUM_VERTS(NUM_VERTS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .z(z),
        .out_valid(out_valid), .out_ready(out_ready),
        .ox(ox), .oy(oy),
        .out_idx(out_idx), .out_last(out_last),
        .out_clip(out_clip), .out_sat(out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint clamp(input longint q);
        if (q > MAXP) return MAXP;
        if (q < -MAXP) return MINN;
        return q;
    endfunction

    // Reference: exact product, division truncating toward zero, then clamp.
    task automatic ref_proj(input int xi, input int yi, input int zi,
                            output longint rx, output longint ry,
                            output bit clip, output bit sat);
        longint qx, qy;
        if (zi < NEAR_Z) begin
            rx = 0; ry = 0; clip = 1'b1; sat = 1'b0;
        end else begin
            qx   = (longint'(xi) * FOCAL_D) / longint'(zi);
            qy   = (longint'(yi) * FOCAL_D) / longint'(zi);
            sat  = (qx > MAXP) || (qx < -MAXP) || (qy > MAXP) || (qy < -MAXP);
            rx   = clamp(qx);
            ry   = clamp(qy);
            clip = 1'b0;
        end
    endtask

    task automatic run_vertex(input int xi, input int yi, input int zi,
                              input int hold, input bit noise);
        longint ex, ey;
        bit     eclip, esat;
        int     lat;
        longint hx, hy;
        ref_proj(xi, yi, zi, ex, ey, eclip, esat);
        @(negedge clk);
        check_eq("in_ready_idle", in_ready, 1);
        x = xi; y = yi; z = zi;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (out_valid || lat > 200) break;
            lat++;
            if (noise) begin
                check_eq("in_ready_busy", in_ready, 0);
                in_valid = 1'($urandom_range(0, 1));
                x = $urandom; y = $urandom; z = $urandom;
            end
        end
        in_valid = 1'b0;
        check_eq("latency", lat, eclip ? 1 : NW + 2);
        check_eq("ox", $signed(ox), ex);
        check_eq("oy", $signed(oy), ey);
        check_eq("clip", out_clip, eclip);
        check_eq("sat", out_sat, esat);
        check_eq("idx", out_idx, idx_ref);
        check_eq("last", out_last, (idx_ref == NUM_VERTS - 1));
        hx = $signed(ox);
        hy = $signed(oy);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            x = $urandom;
            @(negedge clk);
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_ready", in_ready, 0);
            check_eq("hold_ox", $signed(ox), hx);
            check_eq("hold_oy", $signed(oy), hy);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        idx_ref = (idx_ref + 1) % NUM_VERTS;
        check_eq("valid_drop", out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx, ry, rz;
        n_cmp = 0; n_bad = 0; idx_ref = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; z = '0;
        #23;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_ox", ox, 0);
        check_eq("rst_oy", oy, 0);
        check_eq("rst_idx", out_idx, 0);
        check_eq("rst_clip", out_clip, 0);
        check_eq("rst_sat", out_sat, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Primitive of three ordinary vertices.
        run_vertex(35, 40, 800, 0, 0);
        run_vertex(10, 20, 650, 0, 0);
        run_vertex(30, 60, 1000, 0, 0);
        // Sign handling and clip with negative z.
        run_vertex(-35, 40, 800, 0, 0);
        run_vertex(35, -40, -5, 0, 0);
        // Near-plane boundary.
        run_vertex(7, 9, 0, 0, 0);
        run_vertex(7, 9, NEAR_Z - 1, 0, 0);
        run_vertex(1, 0, NEAR_Z, 0, 0);
        // Saturation at both extremes.
        run_vertex(32'h7fffffff, 32'h80000000, 1, 0, 0);
        // Back-pressure with ignored in_valid pulses.
        run_vertex(100, -200, 7, 10, 1);

        // Reset in the middle of a divide.
        @(negedge clk);
        x = 500; y = 500; z = 3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_idx", out_idx, 0);
        idx_ref = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vertex(35, 40, 800, 0, 0);

        // Randomized vertices.
        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 3))
                0: begin rx = $urandom; ry = $urandom; end
                default: begin
                    rx = int'($urandom_range(0, 20000)) - 10000;
                    ry = int'($urandom_range(0, 20000)) - 10000;
                end
            endcase
            case ($urandom_range(0, 7))
                0: rz = -int'($urandom_range(0, 1000));
                1: rz = 1;
                2: rz = int'($urandom_range(1, 32'h7fffffff));
                default: rz = int'($urandom_range(1, 5000));
            endcase
            run_vertex(rx, ry, rz, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
